// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard receiver tracking the first held key
//
// Deserialises 11-bit PS/2 device-to-host frames (start, 8 data LSB first,
// parity, stop) on sys_clk and follows make/break sequences. key shows the scan
// code of the first key pressed and holds it until that key's break sequence
// arrives. Other keys pressed meanwhile are ignored. 0 means "no key".
//
// Ports
//   sys_clk    in   system clock, all logic on the rising edge
//   async_rst  in   asynchronous active-low reset
//   ps2_clk    in   PS/2 clock from the keyboard (asynchronous, idle high)
//   ps2_data   in   PS/2 data from the keyboard (asynchronous, idle high)
//   key        out  scan code of the held primary key, 0 when none

module ps2_receiver #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] BREAK_CODE     = 8'hF0,
    parameter logic [DATA_WIDTH-1:0] EXT_CODE       = 8'hE0,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    TIMEOUT_CYCLES = 200000
) (
    input  logic                  sys_clk,
    input  logic                  async_rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [DATA_WIDTH-1:0] key
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
    logic                    clk_prev_q, clk_prev_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [TW-1:0]           timeout_q, timeout_d;
    logic                    byte_valid_q, byte_valid_d;
    logic                    break_pending_q, break_pending_d;
    logic [DATA_WIDTH-1:0]   key_q, key_d;

    logic clk_cur;
    logic data_cur;
    logic fall;

    assign clk_cur  = clk_sync_q[SYNC_STAGES-1];
    assign data_cur = data_sync_q[SYNC_STAGES-1];
    // Data is sampled in the same cycle the synchronised clock is seen falling.
    assign fall     = clk_prev_q & ~clk_cur;
    assign key      = key_q;

    // Synchronisers and edge-detect history.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_cur;
    end

    // Frame FSM, advanced only on detected falling edges of ps2_clk.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        timeout_d    = '0;
        byte_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall && !data_cur) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {data_cur, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    byte_valid_d = data_cur;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled partial frame is abandoned so a later frame starts clean.
        if (state_q != ST_IDLE && !fall) begin
            if (timeout_q == TO_MAX) begin
                state_d = ST_IDLE;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end
    end

    // Make/break decode. shift_q cannot change before the next frame's data
    // bits, so it still holds the received byte on the cycle after the strobe.
    always_comb begin
        key_d           = key_q;
        break_pending_d = break_pending_q;

        if (byte_valid_q) begin
            if (shift_q == EXT_CODE) begin
                break_pending_d = break_pending_q;
            end else if (shift_q == BREAK_CODE) begin
                break_pending_d = 1'b1;
            end else if (break_pending_q) begin
                if (shift_q == key_q) begin
                    key_d = '0;
                end
                break_pending_d = 1'b0;
            end else if (key_q == '0) begin
                // A 0x00 make code leaves key at 0 naturally.
                key_d = shift_q;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q         <= ST_IDLE;
            clk_sync_q      <= '1;
            data_sync_q     <= '1;
            clk_prev_q      <= 1'b1;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            timeout_q       <= '0;
            byte_valid_q    <= 1'b0;
            break_pending_q <= 1'b0;
            key_q           <= '0;
        end else begin
            state_q         <= state_d;
            clk_sync_q      <= clk_sync_d;
            data_sync_q     <= data_sync_d;
            clk_prev_q      <= clk_prev_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            timeout_q       <= timeout_d;
            byte_valid_q    <= byte_valid_d;
            break_pending_q <= break_pending_d;
            key_q           <= key_d;
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - self-checking bench for ps2_receiver

module tb_ps2_receiver;

    localparam int SYNC    = 2;
    localparam int TIMEOUT = 300;
    localparam int H       = 20;

    logic       sys_clk = 1'b0;
    logic       async_rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp;
        int         gap;
    } vec_t;

    vec_t vecs[$];

    ps2_receiver #(
        .DATA_WIDTH    (8),
        .BREAK_CODE    (8'hF0),
        .EXT_CODE      (8'hE0),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .sys_clk  (sys_clk),
        .async_rst(async_rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (key)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_key(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, key=%02h", name, key);
        end else begin
            exp = exp_q.pop_front();
            if (key !== exp) begin
                errors++;
                $display("FAIL %s: key=%02h expected %02h", name, key, exp);
            end
        end
    endtask

    task automatic expect_now(input string name, input logic [7:0] exp);
        exp_q.push_back(exp);
        check_key(name);
    endtask

    // Put one bit on ps2_data during the high half, then drop ps2_clk.
    task automatic ps2_bit(input logic b);
        @(negedge sys_clk);
        ps2_data = b;
        repeat (H) @(negedge sys_clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_release();
        repeat (H) @(negedge sys_clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; key is checked at the latency bound after the stop-bit fall.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic [7:0] exp, input string name);
        logic [10:0] bits;
        bits = {stop, 1'b1, d, 1'b0};
        exp_q.push_back(exp);
        for (int i = 0; i < 11; i++) begin
            ps2_bit(bits[i]);
            if (i == 10) begin
                repeat (SYNC + 2) @(posedge sys_clk);
                @(negedge sys_clk);
                check_key(name);
                repeat (H - SYNC - 3) @(negedge sys_clk);
                ps2_clk = 1'b1;
            end else begin
                ps2_release();
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic add(input logic [7:0] d, input logic s, input logic [7:0] e, input int g);
        vec_t v;
        v.data = d;
        v.stop = s;
        v.exp  = e;
        v.gap  = g;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] partial;

        // Hold key 0x15 with typematic repeats, then release.
        for (int i = 0; i < 5; i++) add(8'h15, 1'b1, 8'h15, 200);
        add(8'hF0, 1'b1, 8'h15, 50);
        add(8'h15, 1'b1, 8'h00, 0);
        // Primary key held across secondary key presses/releases.
        add(8'h1D, 1'b1, 8'h1D, 50);
        add(8'h1D, 1'b1, 8'h1D, 200);
        add(8'h15, 1'b1, 8'h1D, 0);
        add(8'hF0, 1'b1, 8'h1D, 100);
        add(8'h15, 1'b1, 8'h1D, 0);
        add(8'h2D, 1'b1, 8'h1D, 0);
        add(8'hF0, 1'b1, 8'h1D, 100);
        add(8'h2D, 1'b1, 8'h1D, 0);
        add(8'hF0, 1'b1, 8'h1D, 50);
        add(8'h1D, 1'b1, 8'h00, 0);
        // Stray break of a key that is not held.
        add(8'h1D, 1'b1, 8'h1D, 50);
        add(8'hF0, 1'b1, 8'h1D, 50);
        add(8'h15, 1'b1, 8'h1D, 0);
        add(8'h1C, 1'b1, 8'h1D, 50);
        add(8'hF0, 1'b1, 8'h1D, 50);
        add(8'h1D, 1'b1, 8'h00, 0);
        // 0x00 make code, extended prefix in make and break sequences.
        add(8'h00, 1'b1, 8'h00, 50);
        add(8'hE0, 1'b1, 8'h00, 50);
        add(8'h75, 1'b1, 8'h75, 0);
        add(8'hE0, 1'b1, 8'h75, 50);
        add(8'hF0, 1'b1, 8'h75, 0);
        add(8'h75, 1'b1, 8'h00, 0);
        // Bad stop bit drops the byte.
        add(8'h15, 1'b0, 8'h00, 50);

        // Reset with idle lines: key low during and after.
        repeat (1000) @(negedge sys_clk);
        expect_now("reset_during", 8'h00);
        async_rst = 1'b1;
        repeat (20) @(negedge sys_clk);
        expect_now("reset_after", 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].gap) @(negedge sys_clk);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Truncated frame: start + 3 data bits, then a gap beyond the timeout.
        partial = 8'h1D;
        ps2_bit(1'b0);
        ps2_release();
        for (int i = 0; i < 3; i++) begin
            ps2_bit(partial[i]);
            ps2_release();
        end
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge sys_clk);
        expect_now("trunc_idle", 8'h00);
        send_frame(8'h15, 1'b1, 8'h15, "after_trunc");

        // Reset in the middle of a frame carrying 0x15.
        partial = 8'h15;
        ps2_bit(1'b0);
        ps2_release();
        for (int i = 0; i < 3; i++) begin
            ps2_bit(partial[i]);
            ps2_release();
        end
        @(negedge sys_clk);
        async_rst = 1'b0;
        ps2_data  = 1'b1;
        repeat (20) @(negedge sys_clk);
        expect_now("midframe_rst", 8'h00);
        async_rst = 1'b1;
        repeat (20) @(negedge sys_clk);
        send_frame(8'h1D, 1'b1, 8'h1D, "after_rst");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
